instruction_loader: RTL and testbench
=====================================

# instruction_loader

Writer side of the instruction memory: receives a framed program image over a byte-wide valid/ready stream and writes it word by word into the instruction memory's write port, starting at address 0. While a load is in progress it holds the CPU in reset, and it releases the CPU only after the frame checksum verifies. It sits between the host/debug byte source and the instruction memory, replacing file preload for in-system reprogramming.

## Interface
- ADDR_WIDTH, 8, instruction memory address width; capacity is 2^ADDR_WIDTH words.
- DATA_WIDTH, 8, instruction word width; equals stream byte width.
- SYNC_BYTE, 8'hA5, frame start marker.

- clock  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- inStart  input  1  one-cycle request to begin a load session.
- inValid  input  1  stream byte valid.
- inByte  input  DATA_WIDTH  stream byte.
- outReady  output  1  loader accepts byte this cycle.
- outWriteEnable  output  1  one-cycle memory write strobe.
- outWriteAddress  output  ADDR_WIDTH  memory write address.
- outWriteData  output  DATA_WIDTH  memory write data.
- outCpuHold  output  1  holds CPU in reset while high.
- outBusy  output  1  session active (states SYNC..CHECK).
- outDone  output  1  last session verified OK.
- outError  output  1  last session failed checksum.

## Operation
- Frame: SYNC_BYTE, LEN, LEN data words (LEN=0 means 2^ADDR_WIDTH words), CHK. Valid when (sum of data words + CHK) mod 256 == 0.
- A byte transfers on a rising edge where inValid && outReady are both high.
- States:
  - IDLE: outReady=0. inStart -> SYNC.
  - SYNC: outReady=1. SYNC_BYTE -> LEN. Any other byte is discarded; stay in SYNC.
  - LEN: outReady=1. Byte loads the 9-bit word counter (0 loads 256) and clears address and running sum -> DATA.
  - DATA: outReady=1. Each byte is written, added to the running sum (mod 256) and decrements the counter. Counter reaching 0 -> CHECK.
  - CHECK: outReady=1. Byte added to the sum. Result 0 -> DONE, otherwise -> ERROR.
  - DONE: outReady=0, outDone=1. inStart -> SYNC.
  - ERROR: outReady=0, outError=1. inStart -> SYNC.
- inStart is ignored in SYNC, LEN, DATA and CHECK. inStart arriving in SYNC..CHECK together with a byte has no effect.
- Entering SYNC clears outDone and outError.
- outCpuHold:
  - Set on entering SYNC.
  - Cleared on entering DONE.
  - Stays 1 in ERROR, so the CPU never runs a partial or corrupt image.
- Address: starts at 0, +1 after each write. Wraps from 2^ADDR_WIDTH-1 to 0 only after the final word of a LEN=0 frame. No write ever exceeds the frame length.
- Words past LEN are never written. The byte after the last data word is always taken as CHK.

## Timing
- Reset values:
  - state=IDLE.
  - outReady, outWriteEnable, outCpuHold, outBusy, outDone, outError all 0.
  - outWriteAddress=0, outWriteData=0.
  - After reset the CPU runs the preloaded image.
- All outputs are registered except outReady, which is decoded from state.
- Write latency: a data byte accepted at edge k gives outWriteEnable=1 with that byte's address and data for exactly the cycle after edge k. Address and data hold their values when outWriteEnable=0.
- Throughput: one byte per cycle. Back-to-back data bytes give consecutive write strobes.
- State timing:
  - IDLE->SYNC one edge after inStart.
  - CHECK->DONE/ERROR on the CHK accept edge; outDone, outError and outCpuHold update on that same edge.
  - The final data write strobe precedes the CHECK accept by at least one cycle.
- Reset mid-session: immediate return to IDLE. Memory keeps a partial image, and the session is not resumed.

## Test plan
- Basic load: inStart, then bytes A5,03,01,02,03,FA back-to-back. Required:
  - Writes (0,01),(1,02),(2,03), each one cycle after its accept.
  - outCpuHold high from SYNC until the FA accept, then 0.
  - outDone=1, outError=0.
- Bad checksum: A5,02,10,20,00. Required: two writes, outError=1, outDone=0, outCpuHold stays 1; a new inStart clears outError.
- Sync hunt and stall: 00,FF,A5,01,7E,82 with inValid toggling every other cycle. Required: 00 and FF discarded, one write (0,7E), outDone=1, no writes on idle cycles.
- Full image: LEN=00, 256 words i=0..255 with data=i, CHK=80. Required:
  - 256 writes with address==data.
  - Last write at address FF; address reads 0 afterwards.
  - outDone=1.
- Start ignored and reset mid-session: inStart pulsed during DATA has no effect. Reset asserted after 2 of 5 words gives all outputs 0 on the next sample and state IDLE; a subsequent full frame loads correctly from address 0.

Source files
------------

// File: rtl/instruction_loader_if.sv
// Byte-stream and instruction-memory write-port bundle for the instruction loader.
// slave is the loader side; master is the host/byte source side.
interface instruction_loader_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  inStart;
  logic                  inValid;
  logic [DATA_WIDTH-1:0] inByte;
  logic                  outReady;
  logic                  outWriteEnable;
  logic [ADDR_WIDTH-1:0] outWriteAddress;
  logic [DATA_WIDTH-1:0] outWriteData;
  logic                  outCpuHold;
  logic                  outBusy;
  logic                  outDone;
  logic                  outError;

  modport slave (
    input  inStart, inValid, inByte,
    output outReady, outWriteEnable, outWriteAddress, outWriteData,
    output outCpuHold, outBusy, outDone, outError
  );

  modport master (
    output inStart, inValid, inByte,
    input  outReady, outWriteEnable, outWriteAddress, outWriteData,
    input  outCpuHold, outBusy, outDone, outError
  );
endinterface

// File: rtl/instruction_loader.sv
// Receives a framed program image (SYNC, LEN, data, CHK) over a byte stream and writes it into
// instruction memory from address 0, holding the CPU in reset until the checksum verifies.
module instruction_loader #(
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter int unsigned           DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE  = 8'hA5
) (
  input logic                  clock,
  input logic                  reset,
  instruction_loader_if.slave  bus
);

  localparam int unsigned          CntW      = ADDR_WIDTH + 1;
  localparam logic [CntW-1:0]      CntOne    = 1;
  localparam logic [CntW-1:0]      FullCount = CntOne << ADDR_WIDTH;

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StLen,
    StData,
    StCheck,
    StDone,
    StError
  } state_e;

  state_e                state_q;
  logic [CntW-1:0]       count_q;
  logic [DATA_WIDTH-1:0] sum_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  hold_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  error_q;

  logic                  ready;
  logic                  accept;
  logic [DATA_WIDTH-1:0] sum_next;
  logic [CntW-1:0]       len_count;

  assign ready    = (state_q == StSync) || (state_q == StLen) ||
                    (state_q == StData) || (state_q == StCheck);
  assign accept   = bus.inValid && ready;
  assign sum_next = sum_q + bus.inByte;

  // A zero length byte stands for a full-capacity image.
  always_comb begin
    len_count = CntW'(bus.inByte);
    if (bus.inByte == '0) begin
      len_count = FullCount;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      count_q <= '0;
      sum_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      we_q <= 1'b0;
      // The address advances as each write strobe retires, so it points past the last word.
      if (we_q) begin
        waddr_q <= waddr_q + ADDR_WIDTH'(1);
      end

      case (state_q)
        StIdle, StDone, StError: begin
          if (bus.inStart) begin
            state_q <= StSync;
            busy_q  <= 1'b1;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            error_q <= 1'b0;
          end
        end

        StSync: begin
          if (accept && (bus.inByte == SYNC_BYTE)) begin
            state_q <= StLen;
          end
        end

        StLen: begin
          if (accept) begin
            count_q <= len_count;
            sum_q   <= '0;
            waddr_q <= '0;
            state_q <= StData;
          end
        end

        StData: begin
          if (accept) begin
            we_q    <= 1'b1;
            wdata_q <= bus.inByte;
            sum_q   <= sum_next;
            count_q <= count_q - CntOne;
            if (count_q == CntOne) begin
              state_q <= StCheck;
            end
          end
        end

        StCheck: begin
          if (accept) begin
            sum_q  <= sum_next;
            busy_q <= 1'b0;
            if (sum_next == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
            end else begin
              state_q <= StError;
              error_q <= 1'b1;
            end
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.outReady        = ready;
  assign bus.outWriteEnable  = we_q;
  assign bus.outWriteAddress = waddr_q;
  assign bus.outWriteData    = wdata_q;
  assign bus.outCpuHold      = hold_q;
  assign bus.outBusy         = busy_q;
  assign bus.outDone         = done_q;
  assign bus.outError        = error_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader: frames are modelled from their byte lists, expected
// writes are queued on accept and checked by an independent write monitor.
module tb_instruction_loader;

  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int Half = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #Half clock = ~clock;

  instruction_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  instruction_loader #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    time        t;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] frm[$];
  int         vectors     = 0;
  int         miscompares = 0;
  bit         exp_ok;
  int         exp_n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clock) begin
    wr_t e;
    if (!reset && bus.outWriteEnable === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write at %0t",
                 bus.outWriteAddress, bus.outWriteData, $time);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", 32'(bus.outWriteAddress), 32'(e.addr));
        chk("write_data", 32'(bus.outWriteData), 32'(e.data));
        chk("write_latency", 32'($time), 32'(e.t));
        chk("hold_during_write", 32'(bus.outCpuHold), 32'd1);
      end
    end
  end

  // Reference: locate the frame in the byte list and derive length and checksum verdict.
  task automatic model_frame();
    int         s;
    logic [7:0] sum;
    s = -1;
    for (int i = 0; i < frm.size(); i++) begin
      if (s < 0 && frm[i] == 8'hA5) s = i;
    end
    exp_n = (frm[s+1] == 8'h00) ? 256 : int'(frm[s+1]);
    sum = 8'h00;
    for (int j = 0; j <= exp_n; j++) sum = sum + frm[s+2+j];
    exp_ok = (sum == 8'h00);
  endtask

  task automatic send_frame(input int gap, input int start_at, input int limit);
    int  s;
    int  last;
    int  waits;
    bit  acc;
    model_frame();
    s = -1;
    for (int i = 0; i < frm.size(); i++) begin
      if (s < 0 && frm[i] == 8'hA5) s = i;
    end
    last = (limit < 0) ? frm.size() : limit;
    for (int i = 0; i < last; i++) begin
      repeat (gap) begin
        @(negedge clock);
        bus.inValid = 1'b0;
        bus.inStart = 1'b0;
      end
      if (i == start_at) begin
        @(negedge clock);
        bus.inValid = 1'b0;
        bus.inStart = 1'b1;
      end
      @(negedge clock);
      bus.inValid = 1'b1;
      bus.inByte  = frm[i];
      bus.inStart = (i == start_at);
      waits = 0;
      forever begin
        acc = bus.outReady;
        @(posedge clock);
        if (acc) break;
        waits++;
        if (waits > 20) begin
          vectors++;
          miscompares++;
          $display("FAIL accept_timeout: byte %0d not accepted, expected ready", i);
          return;
        end
        @(negedge clock);
      end
      if (i >= s + 2 && i < s + 2 + exp_n) begin
        exp_q.push_back('{addr: 8'(i - s - 2), data: frm[i], t: $time + Half});
      end
    end
    @(negedge clock);
    bus.inValid = 1'b0;
    bus.inStart = 1'b0;
  endtask

  task automatic check_end(input string tag);
    @(negedge clock);
    chk({tag, "_done"}, 32'(bus.outDone), 32'(exp_ok));
    chk({tag, "_error"}, 32'(bus.outError), 32'(!exp_ok));
    chk({tag, "_hold"}, 32'(bus.outCpuHold), 32'(!exp_ok));
    chk({tag, "_busy"}, 32'(bus.outBusy), 32'd0);
    chk({tag, "_ready"}, 32'(bus.outReady), 32'd0);
    chk({tag, "_addr_after"}, 32'(bus.outWriteAddress), 32'(exp_n % 256));
    chk({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic start_session();
    @(negedge clock);
    bus.inStart = 1'b1;
    @(negedge clock);
    bus.inStart = 1'b0;
    chk("start_busy", 32'(bus.outBusy), 32'd1);
    chk("start_hold", 32'(bus.outCpuHold), 32'd1);
    chk("start_done_clr", 32'(bus.outDone), 32'd0);
    chk("start_error_clr", 32'(bus.outError), 32'd0);
    chk("start_ready", 32'(bus.outReady), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(bus.outReady), 32'd0);
    chk({tag, "_we"}, 32'(bus.outWriteEnable), 32'd0);
    chk({tag, "_addr"}, 32'(bus.outWriteAddress), 32'd0);
    chk({tag, "_data"}, 32'(bus.outWriteData), 32'd0);
    chk({tag, "_hold"}, 32'(bus.outCpuHold), 32'd0);
    chk({tag, "_busy"}, 32'(bus.outBusy), 32'd0);
    chk({tag, "_done"}, 32'(bus.outDone), 32'd0);
    chk({tag, "_error"}, 32'(bus.outError), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] sum;
    int         len;
    logic [7:0] b;
    bus.inStart = 1'b0;
    bus.inValid = 1'b0;
    bus.inByte  = 8'h00;

    #1;
    check_all_zero("reset");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_ready", 32'(bus.outReady), 32'd0);

    // Basic load.
    start_session();
    frm = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hFA};
    send_frame(0, -1, -1);
    check_end("basic");

    // Bad checksum.
    start_session();
    frm = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
    send_frame(0, -1, -1);
    check_end("badchk");

    // Sync hunt with inValid toggling.
    start_session();
    frm = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h82};
    send_frame(1, -1, -1);
    check_end("hunt");

    // Full image, data equals address.
    start_session();
    frm = '{8'hA5, 8'h00};
    for (int i = 0; i < 256; i++) frm.push_back(8'(i));
    frm.push_back(8'h80);
    send_frame(0, -1, -1);
    check_end("full");

    // inStart pulsed during DATA, both alone and together with a byte.
    start_session();
    frm = '{8'hA5, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    frm.push_back(8'(-(8'h11 + 8'h22 + 8'h33 + 8'h44 + 8'h55)));
    send_frame(0, 4, -1);
    check_end("start_ignored");

    // Randomized frames with garbage prefix, gaps and occasional corrupt checksum.
    for (int r = 0; r < 10; r++) begin
      start_session();
      frm = {};
      repeat ($urandom_range(0, 3)) begin
        do b = 8'($urandom); while (b == 8'hA5);
        frm.push_back(b);
      end
      len = $urandom_range(1, 12);
      frm.push_back(8'hA5);
      frm.push_back(8'(len));
      sum = 8'h00;
      for (int j = 0; j < len; j++) begin
        b = 8'($urandom);
        sum = sum + b;
        frm.push_back(b);
      end
      b = 8'h00 - sum;
      if ($urandom_range(0, 3) == 0) b = b + 8'($urandom_range(1, 255));
      frm.push_back(b);
      send_frame($urandom_range(0, 2), -1, -1);
      check_end("random");
    end

    // Reset mid-session after two of five words.
    start_session();
    frm = '{8'hA5, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hF1};
    send_frame(0, -1, 4);
    #1;
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    chk("midreset_pending_writes", 32'(exp_q.size()), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("midreset_idle_ready", 32'(bus.outReady), 32'd0);
    chk("midreset_idle_busy", 32'(bus.outBusy), 32'd0);

    // Full frame after reset loads from address 0.
    start_session();
    frm = '{8'hA5, 8'h00};
    for (int i = 0; i < 256; i++) frm.push_back(8'(i) ^ 8'h5A);
    frm.push_back(8'h80);
    send_frame(0, -1, -1);
    check_end("after_reset");

    repeat (3) @(negedge clock);
    chk("final_pending_writes", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
